// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues ROM word reads over req/gnt/rvalid and
// presents buffered {inst, instaddr} pairs from a small prefetch FIFO to the IF/ID register.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] INST_NOP = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic [4:0]  hold_en_i,
    output logic        rom_req_o,
    output logic [31:0] rom_addr_o,
    input  logic        rom_gnt_i,
    input  logic        rom_rvalid_i,
    input  logic [31:0] rom_data_i,
    output logic [31:0] inst_o,
    output logic [31:0] instaddr_o,
    output logic        inst_valid_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W:0]   DEPTH_S = (CNT_W + 1)'(DEPTH);

    logic [31:0]      fetch_pc;
    logic [31:0]      last_addr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] drop;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] aq_rd;
    logic [PTR_W-1:0] aq_wr;
    logic [31:0]      data_mem [DEPTH];
    logic [31:0]      addr_mem [DEPTH];
    logic [31:0]      aq_mem   [DEPTH];

    logic [CNT_W:0]   inflight;
    logic             credit;
    logic             issue;
    logic             rsp;
    logic             push;
    logic             pop;
    logic             empty;
    logic             unused_hold;

    assign unused_hold = ^hold_en_i[4:1];

    // Dropped (post-jump) reads still hold credit, so a push can never find the FIFO full.
    assign inflight  = {1'b0, count} + {1'b0, outstanding};
    assign credit    = inflight < DEPTH_S;
    assign rom_req_o = !rstn && !jump_en_i && credit;
    assign rom_addr_o = fetch_pc;
    assign issue     = rom_req_o && rom_gnt_i;

    // A response with nothing outstanding belongs to a read abandoned by reset.
    assign rsp  = rom_rvalid_i && (outstanding != '0);
    assign push = !rstn && rsp && (drop == '0) && !jump_en_i;

    assign empty        = (count == '0);
    assign inst_valid_o = !empty;
    assign pop          = inst_valid_o && !hold_en_i[0] && !jump_en_i;
    assign inst_o       = empty ? INST_NOP : data_mem[rd_ptr];
    assign instaddr_o   = empty ? last_addr : addr_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rstn) begin
            fetch_pc    <= RESET_PC;
            last_addr   <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            aq_rd       <= '0;
            aq_wr       <= '0;
        end else begin
            if (inst_valid_o) begin
                last_addr <= instaddr_o;
            end
            if (jump_en_i) begin
                fetch_pc    <= jump_addr_i;
                count       <= '0;
                rd_ptr      <= '0;
                wr_ptr      <= '0;
                aq_rd       <= '0;
                aq_wr       <= '0;
                outstanding <= outstanding - CNT_W'(rsp);
                drop        <= outstanding - CNT_W'(rsp);
            end else begin
                if (issue) begin
                    fetch_pc <= fetch_pc + 32'd4;
                    aq_wr    <= aq_wr + PTR_W'(1);
                end
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                    aq_rd  <= aq_rd + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                count       <= count + CNT_W'(push) - CNT_W'(pop);
                outstanding <= outstanding + CNT_W'(issue) - CNT_W'(rsp);
                if (rsp && (drop != '0)) begin
                    drop <= drop - CNT_W'(1);
                end
            end
        end
    end

    // Storage needs no reset: occupancy is tracked entirely by the counters above.
    always_ff @(posedge clk) begin
        if (issue) begin
            aq_mem[aq_wr] <= fetch_pc;
        end
        if (push) begin
            data_mem[wr_ptr] <= rom_data_i;
            addr_mem[wr_ptr] <= aq_mem[aq_rd];
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rstn) push |-> (count != DEPTH_C));

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed and randomized checks of ifu_fetch against a behavioural ROM responder.
module tb_ifu_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rstn;
    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic [4:0]  hold_en_i;
    logic        rom_req_o;
    logic [31:0] rom_addr_o;
    logic        rom_gnt_i;
    logic        rom_rvalid_i;
    logic [31:0] rom_data_i;
    logic [31:0] inst_o;
    logic [31:0] instaddr_o;
    logic        inst_valid_o;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int gnt_mode = 0;
    int lat_min = 1;
    int lat_max = 1;
    logic [31:0] pend_addr [$];
    int          pend_due  [$];
    logic        obs_req;
    logic [31:0] obs_addr;

    ifu_fetch #(.RESET_PC(RESET_PC), .DEPTH(2), .INST_NOP(INST_NOP)) dut (
        .clk(clk), .rstn(rstn), .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
        .hold_en_i(hold_en_i), .rom_req_o(rom_req_o), .rom_addr_o(rom_addr_o),
        .rom_gnt_i(rom_gnt_i), .rom_rvalid_i(rom_rvalid_i), .rom_data_i(rom_data_i),
        .inst_o(inst_o), .instaddr_o(instaddr_o), .inst_valid_o(inst_valid_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
    endfunction

    // One clock: drive the ROM side, record the issue seen before the edge, then step past the edge.
    task automatic tick();
        int due;
        logic [31:0] dummy_a;
        int dummy_d;
        if (gnt_mode == 0) rom_gnt_i = 1'b1;
        else if (gnt_mode == 1) rom_gnt_i = 1'b0;
        else rom_gnt_i = ($urandom_range(0, 3) != 0);
        rom_rvalid_i = 1'b0;
        rom_data_i = 32'h0;
        if (rstn) begin
            if (pend_addr.size() != 0) begin
                rom_rvalid_i = 1'b1;
                rom_data_i = 32'hDEAD_BEEF;
            end
        end else if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
            rom_rvalid_i = 1'b1;
            rom_data_i = rom_word(pend_addr[0]);
            dummy_a = pend_addr.pop_front();
            dummy_d = pend_due.pop_front();
        end
        #2;
        obs_req = rom_req_o;
        obs_addr = rom_addr_o;
        if (rstn) begin
            pend_addr.delete();
            pend_due.delete();
        end else if (rom_req_o && rom_gnt_i) begin
            due = cyc + int'($urandom_range(lat_min, lat_max));
            if (pend_due.size() != 0 && due <= pend_due[pend_due.size()-1])
                due = pend_due[pend_due.size()-1] + 1;
            pend_addr.push_back(rom_addr_o);
            pend_due.push_back(due);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rstn = 1'b1;
        jump_en_i = 1'b0;
        jump_addr_i = 32'h0;
        hold_en_i = 5'b0;
        gnt_mode = 0;
        lat_min = 1;
        lat_max = 1;
        tick();
        rstn = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b1;
        jump_en_i = 1'b0;
        jump_addr_i = 32'h0;
        hold_en_i = 5'b0;
        gnt_mode = 0;
        tick();
        tick();
        n_cmp++; if (rom_req_o !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", rom_req_o); end
        n_cmp++; if (inst_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", inst_valid_o); end
        n_cmp++; if (inst_o !== INST_NOP) begin n_bad++; $display("FAIL reset_inst: got %h want %h", inst_o, INST_NOP); end
        n_cmp++; if (instaddr_o !== RESET_PC) begin n_bad++; $display("FAIL reset_instaddr: got %h want %h", instaddr_o, RESET_PC); end
        n_cmp++; if (rom_addr_o !== RESET_PC) begin n_bad++; $display("FAIL reset_rom_addr: got %h want %h", rom_addr_o, RESET_PC); end
        rstn = 1'b0;
    endtask

    // Full-rate grant, 1-cycle response; upper hold bits set to show only bit0 stalls.
    task automatic test_stream();
        logic        er [9];
        logic [31:0] ra [9];
        logic        ev [9];
        logic [31:0] ea [9];
        er = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        ra = '{32'd0, 32'd4, 32'd8, 32'd8, 32'd12, 32'd16, 32'd16, 32'd20, 32'd24};
        ev = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        ea = '{32'd0, 32'd0, 32'd4, 32'd4, 32'd8, 32'd12, 32'd12, 32'd16, 32'd20};
        do_reset();
        hold_en_i = 5'b11110;
        for (int k = 0; k < 9; k++) begin
            tick();
            n_cmp++; if (obs_req !== er[k]) begin n_bad++; $display("FAIL stream_req[%0d]: got %b want %b", k, obs_req, er[k]); end
            n_cmp++; if (obs_addr !== ra[k]) begin n_bad++; $display("FAIL stream_rom_addr[%0d]: got %h want %h", k, obs_addr, ra[k]); end
            n_cmp++; if (inst_valid_o !== ev[k]) begin n_bad++; $display("FAIL stream_valid[%0d]: got %b want %b", k, inst_valid_o, ev[k]); end
            n_cmp++; if (instaddr_o !== ea[k]) begin n_bad++; $display("FAIL stream_instaddr[%0d]: got %h want %h", k, instaddr_o, ea[k]); end
            n_cmp++; if (inst_o !== (ev[k] ? rom_word(ea[k]) : INST_NOP)) begin
                n_bad++; $display("FAIL stream_inst[%0d]: got %h want %h", k, inst_o, ev[k] ? rom_word(ea[k]) : INST_NOP);
            end
        end
        hold_en_i = 5'b0;
    endtask

    task automatic test_hold();
        logic        er [8];
        logic [31:0] ra [8];
        logic        ev [8];
        logic [31:0] ea [8];
        er = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        ra = '{32'd0, 32'd4, 32'd8, 32'd8, 32'd8, 32'd8, 32'd12, 32'd16};
        ev = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        ea = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd4, 32'd4, 32'd8, 32'd12};
        do_reset();
        for (int k = 0; k < 8; k++) begin
            hold_en_i = (k < 4) ? 5'b00001 : 5'b00000;
            tick();
            n_cmp++; if (obs_req !== er[k]) begin n_bad++; $display("FAIL hold_req[%0d]: got %b want %b", k, obs_req, er[k]); end
            n_cmp++; if (obs_addr !== ra[k]) begin n_bad++; $display("FAIL hold_rom_addr[%0d]: got %h want %h", k, obs_addr, ra[k]); end
            n_cmp++; if (inst_valid_o !== ev[k]) begin n_bad++; $display("FAIL hold_valid[%0d]: got %b want %b", k, inst_valid_o, ev[k]); end
            n_cmp++; if (instaddr_o !== ea[k]) begin n_bad++; $display("FAIL hold_instaddr[%0d]: got %h want %h", k, instaddr_o, ea[k]); end
            if (ev[k]) begin
                n_cmp++; if (inst_o !== rom_word(ea[k])) begin n_bad++; $display("FAIL hold_inst[%0d]: got %h want %h", k, inst_o, rom_word(ea[k])); end
            end
        end
    endtask

    // Two reads in flight at the jump; both late responses must be discarded.
    task automatic test_jump();
        logic        er [9];
        logic [31:0] ra [9];
        logic        ev [9];
        logic [31:0] ea [9];
        er = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        ra = '{32'h0, 32'h4, 32'h8, 32'h100, 32'h100, 32'h104, 32'h108, 32'h108, 32'h108};
        ev = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        ea = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h100, 32'h104};
        do_reset();
        lat_min = 3;
        lat_max = 3;
        for (int k = 0; k < 9; k++) begin
            jump_en_i = (k == 2);
            jump_addr_i = 32'h100;
            tick();
            n_cmp++; if (obs_req !== er[k]) begin n_bad++; $display("FAIL jump_req[%0d]: got %b want %b", k, obs_req, er[k]); end
            n_cmp++; if (obs_addr !== ra[k]) begin n_bad++; $display("FAIL jump_rom_addr[%0d]: got %h want %h", k, obs_addr, ra[k]); end
            n_cmp++; if (inst_valid_o !== ev[k]) begin n_bad++; $display("FAIL jump_valid[%0d]: got %b want %b", k, inst_valid_o, ev[k]); end
            n_cmp++; if (instaddr_o !== ea[k]) begin n_bad++; $display("FAIL jump_instaddr[%0d]: got %h want %h", k, instaddr_o, ea[k]); end
            if (ev[k]) begin
                n_cmp++; if (inst_o !== rom_word(ea[k])) begin n_bad++; $display("FAIL jump_inst[%0d]: got %h want %h", k, inst_o, rom_word(ea[k])); end
            end
        end
        jump_en_i = 1'b0;
    endtask

    // Jump while the output is held and the FIFO is full: flush wins, target issues next cycle.
    task automatic test_jump_held();
        do_reset();
        hold_en_i = 5'b00001;
        repeat (4) tick();
        n_cmp++; if (inst_valid_o !== 1'b1) begin n_bad++; $display("FAIL jheld_full_valid: got %b want 1", inst_valid_o); end
        jump_en_i = 1'b1;
        jump_addr_i = 32'h200;
        tick();
        n_cmp++; if (obs_req !== 1'b0) begin n_bad++; $display("FAIL jheld_jump_req: got %b want 0", obs_req); end
        n_cmp++; if (inst_valid_o !== 1'b0) begin n_bad++; $display("FAIL jheld_flush_valid: got %b want 0", inst_valid_o); end
        n_cmp++; if (inst_o !== INST_NOP) begin n_bad++; $display("FAIL jheld_flush_inst: got %h want %h", inst_o, INST_NOP); end
        jump_en_i = 1'b0;
        tick();
        n_cmp++; if (obs_req !== 1'b1) begin n_bad++; $display("FAIL jheld_target_req: got %b want 1", obs_req); end
        n_cmp++; if (obs_addr !== 32'h200) begin n_bad++; $display("FAIL jheld_target_addr: got %h want 200", obs_addr); end
        tick();
        n_cmp++; if (inst_valid_o !== 1'b1) begin n_bad++; $display("FAIL jheld_target_valid: got %b want 1", inst_valid_o); end
        n_cmp++; if (instaddr_o !== 32'h200) begin n_bad++; $display("FAIL jheld_target_instaddr: got %h want 200", instaddr_o); end
        n_cmp++; if (inst_o !== rom_word(32'h200)) begin n_bad++; $display("FAIL jheld_target_inst: got %h want %h", inst_o, rom_word(32'h200)); end
        hold_en_i = 5'b0;
    endtask

    task automatic test_gnt_stall();
        int          gm [8];
        logic        er [8];
        logic [31:0] ra [8];
        logic        ev [8];
        logic [31:0] ea [8];
        gm = '{0, 0, 1, 1, 1, 1, 0, 0};
        er = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        ra = '{32'd0, 32'd4, 32'd8, 32'd8, 32'd8, 32'd8, 32'd8, 32'd12};
        ev = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        ea = '{32'd0, 32'd0, 32'd4, 32'd4, 32'd4, 32'd4, 32'd4, 32'd8};
        do_reset();
        for (int k = 0; k < 8; k++) begin
            gnt_mode = gm[k];
            tick();
            n_cmp++; if (obs_req !== er[k]) begin n_bad++; $display("FAIL gstall_req[%0d]: got %b want %b", k, obs_req, er[k]); end
            n_cmp++; if (obs_addr !== ra[k]) begin n_bad++; $display("FAIL gstall_rom_addr[%0d]: got %h want %h", k, obs_addr, ra[k]); end
            n_cmp++; if (inst_valid_o !== ev[k]) begin n_bad++; $display("FAIL gstall_valid[%0d]: got %b want %b", k, inst_valid_o, ev[k]); end
            n_cmp++; if (instaddr_o !== ea[k]) begin n_bad++; $display("FAIL gstall_instaddr[%0d]: got %h want %h", k, instaddr_o, ea[k]); end
            n_cmp++; if (inst_o !== (ev[k] ? rom_word(ea[k]) : INST_NOP)) begin
                n_bad++; $display("FAIL gstall_inst[%0d]: got %h want %h", k, inst_o, ev[k] ? rom_word(ea[k]) : INST_NOP);
            end
        end
        gnt_mode = 0;
    endtask

    // Reset with a read in flight; its response lands in the reset cycle and must vanish.
    task automatic test_reset_midflight();
        do_reset();
        repeat (7) tick();
        n_cmp++; if (instaddr_o !== 32'd12) begin n_bad++; $display("FAIL rmid_pre_instaddr: got %h want c", instaddr_o); end
        rstn = 1'b1;
        tick();
        n_cmp++; if (rom_req_o !== 1'b0) begin n_bad++; $display("FAIL rmid_req: got %b want 0", rom_req_o); end
        n_cmp++; if (inst_valid_o !== 1'b0) begin n_bad++; $display("FAIL rmid_valid: got %b want 0", inst_valid_o); end
        n_cmp++; if (inst_o !== INST_NOP) begin n_bad++; $display("FAIL rmid_inst: got %h want %h", inst_o, INST_NOP); end
        n_cmp++; if (instaddr_o !== RESET_PC) begin n_bad++; $display("FAIL rmid_instaddr: got %h want %h", instaddr_o, RESET_PC); end
        n_cmp++; if (rom_addr_o !== RESET_PC) begin n_bad++; $display("FAIL rmid_rom_addr: got %h want %h", rom_addr_o, RESET_PC); end
        rstn = 1'b0;
        tick();
        n_cmp++; if (obs_req !== 1'b1 || obs_addr !== RESET_PC) begin n_bad++; $display("FAIL rmid_restart: got req %b addr %h want req 1 addr %h", obs_req, obs_addr, RESET_PC); end
        n_cmp++; if (inst_valid_o !== 1'b0) begin n_bad++; $display("FAIL rmid_stale_valid: got %b want 0", inst_valid_o); end
        tick();
        n_cmp++; if (inst_valid_o !== 1'b1 || instaddr_o !== RESET_PC) begin n_bad++; $display("FAIL rmid_first: got valid %b addr %h want valid 1 addr %h", inst_valid_o, instaddr_o, RESET_PC); end
        n_cmp++; if (inst_o !== rom_word(RESET_PC)) begin n_bad++; $display("FAIL rmid_first_inst: got %h want %h", inst_o, rom_word(RESET_PC)); end
    endtask

    task automatic test_random();
        logic [31:0] exp_addr;
        logic        v_before;
        int          pops;
        do_reset();
        gnt_mode = 2;
        lat_min = 1;
        lat_max = 5;
        exp_addr = RESET_PC;
        pops = 0;
        for (int i = 0; i < 3000; i++) begin
            hold_en_i = ($urandom_range(0, 3) == 0) ? 5'b00001 : 5'b00000;
            jump_en_i = ($urandom_range(0, 39) == 0);
            jump_addr_i = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
            v_before = inst_valid_o;
            tick();
            if (jump_en_i) begin
                exp_addr = jump_addr_i;
            end else if (v_before && !hold_en_i[0]) begin
                exp_addr = exp_addr + 32'd4;
                pops++;
            end
            if (inst_valid_o) begin
                n_cmp++; if (instaddr_o !== exp_addr) begin n_bad++; $display("FAIL rand_instaddr@%0d: got %h want %h", i, instaddr_o, exp_addr); end
                n_cmp++; if (inst_o !== rom_word(instaddr_o)) begin n_bad++; $display("FAIL rand_inst@%0d: got %h want %h", i, inst_o, rom_word(instaddr_o)); end
            end
        end
        n_cmp++; if (pops < 200) begin n_bad++; $display("FAIL rand_throughput: got %0d pops want >= 200", pops); end
        jump_en_i = 1'b0;
        hold_en_i = 5'b0;
        gnt_mode = 0;
    endtask

    initial begin
        rstn = 1'b1;
        jump_en_i = 1'b0;
        jump_addr_i = 32'h0;
        hold_en_i = 5'b0;
        rom_gnt_i = 1'b0;
        rom_rvalid_i = 1'b0;
        rom_data_i = 32'h0;
        test_reset();
        test_stream();
        test_hold();
        test_jump();
        test_jump_held();
        test_gnt_stall();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
